// File: rtl/cctl_spi_master_if.sv
// CCTL cartridge-bus side of the SPI master: select, direction, address and data.
interface cctl_spi_master_if;
    logic       cctl_n;
    logic       r_w;
    logic [7:0] cart_a;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_oe;

    modport master (output cctl_n, r_w, cart_a, din, input dout, dout_oe);
    modport slave  (input cctl_n, r_w, cart_a, din, output dout, dout_oe);
endinterface

// File: rtl/cctl_spi_master.sv
// Byte-wide SPI master (mode 0) mapped into the CCTL window: DATA at offset 0, CTRL/STATUS at 1.
// Define CCTL_SPI_LSB_FIRST_EN to shift and assemble bytes LSB first (default MSB first).
module cctl_spi_master #(
    parameter logic [4:0] WINDOW = 5'b10111
) (
    input  logic               phi2,
    input  logic               rst,
    cctl_spi_master_if.slave   bus,
    output logic               sck,
    output logic               mosi,
    input  logic               miso,
    output logic               cs_n
);

`ifdef CCTL_SPI_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LO = 2'd1, S_HI = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        acc, wr_data, rd_data, wr_ctrl;
    logic [2:0]  off;
    logic [1:0]  hcnt, div_lat, div_reg;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx_sr, rx_sr, rx;
    logic        busy, done, ovr;
    logic        half_end, start, last;

    assign off     = bus.cart_a[2:0];
    assign acc     = ~bus.cctl_n & (bus.cart_a[7:3] == WINDOW);
    assign wr_data = acc & ~bus.r_w & (off == 3'd0);
    assign rd_data = acc &  bus.r_w & (off == 3'd0);
    assign wr_ctrl = acc & ~bus.r_w & (off == 3'd1);

    assign half_end = (hcnt == div_lat);
    assign start    = wr_data & (state == S_IDLE);
    // Completion edge; a DATA write landing here still sees busy and counts as overrun.
    assign last     = (state == S_HI) & half_end & (bit_cnt == 3'd7);

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (wr_data)  state_nxt = S_LO;
            S_LO:    if (half_end) state_nxt = S_HI;
            S_HI:    if (half_end) state_nxt = (bit_cnt == 3'd7) ? S_IDLE : S_LO;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sck  = (state == S_HI);
        busy = (state != S_IDLE);
    end

    // Shift datapath: mosi is registered so it stays put through IDLE.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            hcnt    <= 2'd0;
            div_lat <= 2'd0;
            bit_cnt <= 3'd0;
            tx_sr   <= 8'h00;
            rx_sr   <= 8'h00;
            mosi    <= 1'b0;
        end else if (start) begin
            hcnt    <= 2'd0;
            div_lat <= div_reg;
            bit_cnt <= 3'd0;
            tx_sr   <= bus.din;
            mosi    <= LSB_FIRST ? bus.din[0] : bus.din[7];
        end else if (state != S_IDLE) begin
            if (half_end) begin
                hcnt <= 2'd0;
                if (state == S_LO) begin
                    rx_sr <= LSB_FIRST ? {miso, rx_sr[7:1]} : {rx_sr[6:0], miso};
                end else if (bit_cnt != 3'd7) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    tx_sr   <= LSB_FIRST ? (tx_sr >> 1) : (tx_sr << 1);
                    mosi    <= LSB_FIRST ? tx_sr[1] : tx_sr[6];
                end
            end else begin
                hcnt <= hcnt + 2'd1;
            end
        end
    end

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            rx      <= 8'h00;
            done    <= 1'b0;
            ovr     <= 1'b0;
            cs_n    <= 1'b1;
            div_reg <= 2'b00;
        end else begin
            if (last) rx <= rx_sr;
            if (last)                   done <= 1'b1;
            else if (start | rd_data)   done <= 1'b0;
            if (wr_ctrl) begin
                cs_n    <= ~bus.din[0];
                div_reg <= bus.din[2:1];
                ovr     <= 1'b0;
            end else if (wr_data & busy) begin
                ovr <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.dout_oe = acc & bus.r_w & phi2;
        bus.dout    = 8'h00;
        case (off)
            3'd0:    bus.dout = rx;
            3'd1:    bus.dout = {~cs_n, 2'b00, div_reg, ovr, done, busy};
            default: bus.dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_cctl_spi_master.sv
// Randomized bench for cctl_spi_master: transaction-level model feeding read and mosi scoreboards.
module tb_cctl_spi_master;
    localparam logic [4:0] WIN = 5'b10111;
`ifdef CCTL_SPI_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic phi2 = 1'b0;
    logic rst  = 1'b1;
    logic sck, mosi, miso, cs_n;

    cctl_spi_master_if bus ();

    cctl_spi_master #(.WINDOW(WIN)) dut (
        .phi2(phi2), .rst(rst), .bus(bus),
        .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 phi2 = ~phi2;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    always @(posedge phi2) cyc <= cyc + 1;

    // Transaction-level model of the register file and the transfer in flight.
    bit          m_cs, m_ovr, m_done, m_xfer, m_last;
    logic [1:0]  m_div;
    logic [7:0]  m_rx, m_rx_next;
    int unsigned m_w, m_h, m_end, xh, t_rise;
    logic [7:0]  rdq[$];
    bit          mq[$];
    bit          exp_oe = 1'b0;
    bit          loop = 1'b0;
    logic [7:0]  pat = 8'h00;
    logic [3:0]  ridx = 4'd0;

    assign miso = loop ? mosi : (LSB ? pat[ridx[2:0]] : pat[3'd7 - ridx[2:0]]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_cs = 0; m_ovr = 0; m_done = 0; m_xfer = 0; m_div = 2'b00; m_rx = 8'h00;
    endtask

    task automatic m_sync();
        if (m_xfer && cyc >= m_end) begin
            m_xfer = 0; m_done = 1; m_rx = m_rx_next;
        end
    endtask

    function automatic logic [7:0] m_stat();
        return {m_cs, 2'b00, m_div, m_ovr, m_done, m_xfer};
    endfunction

    task automatic m_start(input logic [7:0] d);
        m_w    = cyc + 1;
        m_h    = int'(m_div) + 1;
        m_end  = m_w + 16 * m_h;
        xh     = m_h;
        m_xfer = 1; m_done = 0;
        m_rx_next = loop ? d : pat;
        ridx   = 4'd0;
        for (int i = 0; i < 8; i++) mq.push_back(LSB ? d[i] : d[7-i]);
        m_last = LSB ? d[7] : d[0];
    endtask

    // One bus cycle: called at posedge+1, returns at the next posedge+1.
    task automatic acc(input bit inwin, input logic [2:0] off, input bit rw, input logic [7:0] d);
        logic [4:0] hi;
        m_sync();
        hi = inwin ? WIN : (WIN ^ 5'($urandom_range(1, 31)));
        bus.cctl_n = 1'b0; bus.r_w = rw; bus.cart_a = {hi, off}; bus.din = d;
        exp_oe = inwin & rw;
        if (inwin) begin
            if (rw) begin
                case (off)
                    3'd0:    begin rdq.push_back(m_rx); m_done = 0; end
                    3'd1:    rdq.push_back(m_stat());
                    default: rdq.push_back(8'h00);
                endcase
            end else if (off == 3'd0) begin
                if (m_xfer) m_ovr = 1;
                else        m_start(d);
            end else if (off == 3'd1) begin
                m_cs = d[0]; m_div = d[2:1]; m_ovr = 0;
            end
        end
        @(posedge phi2); #1;
        bus.cctl_n = 1'b1; bus.r_w = 1'b1; bus.cart_a = 8'h00; bus.din = 8'h00;
        exp_oe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge phi2); #1; end
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) idle(1);
    endtask

    // Read scoreboard: sampled mid phi2-high.
    always @(posedge phi2) begin
        #3;
        if (!bus.cctl_n) check("dout_oe", bus.dout_oe, exp_oe);
        if (bus.dout_oe) begin
            if (rdq.size() == 0) check("dout_oe_extra", bus.dout_oe, 0);
            else                 check("dout", bus.dout, rdq.pop_front());
        end
    end

    // SPI scoreboard: bit order and sck timing.
    always @(posedge sck) begin
        #2;
        if (!rst) begin
            if (mq.size() == 0) check("sck_unexpected", sck, 0);
            else                check("mosi", mosi, mq.pop_front());
            if (ridx == 4'd0) check("first_rise", cyc - m_w, m_h);
            t_rise = cyc;
            ridx   = ridx + 4'd1;
        end
    end

    always @(negedge sck) begin
        #2;
        if (!rst) check("sck_high", cyc - t_rise, xh);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus.cctl_n = 1'b1; bus.r_w = 1'b1; bus.cart_a = 8'h00; bus.din = 8'h00;
        m_reset();
        repeat (3) @(posedge phi2); #1;
        check("rst_sck", sck, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_mosi", mosi, 0);
        rst = 1'b0;
        idle(1);
        acc(1, 3'd1, 1, 8'h00);
        acc(1, 3'd0, 1, 8'h00);

        // Loopback, H=1
        loop = 1'b1;
        acc(1, 3'd1, 0, 8'h01);
        acc(1, 3'd0, 0, 8'hA5);
        wait_until(m_end - 1);
        acc(1, 3'd1, 1, 8'h00);
        acc(1, 3'd1, 1, 8'h00);
        check("mosi_hold", mosi, m_last);
        check("sck_idle", sck, 0);
        acc(1, 3'd0, 1, 8'h00);
        acc(1, 3'd1, 1, 8'h00);

        // Divider H=4 with overrun and its clear
        loop = 1'b0; pat = 8'($urandom);
        acc(1, 3'd1, 0, 8'h07);
        acc(1, 3'd0, 0, 8'h3C);
        idle(10);
        acc(1, 3'd1, 1, 8'h00);
        acc(1, 3'd0, 0, 8'($urandom));
        acc(1, 3'd1, 1, 8'h00);
        acc(1, 3'd1, 0, 8'h07);
        acc(1, 3'd1, 1, 8'h00);
        wait_until(m_end - 1);
        acc(1, 3'd1, 1, 8'h00);
        acc(1, 3'd1, 1, 8'h00);
        acc(1, 3'd0, 1, 8'h00);

        // Collisions with the completion edge
        pat = 8'($urandom);
        acc(1, 3'd1, 0, 8'h01);
        acc(1, 3'd0, 0, 8'($urandom));
        wait_until(m_end - 1);
        acc(1, 3'd0, 0, 8'h55);
        acc(1, 3'd1, 1, 8'h00);
        acc(1, 3'd0, 0, 8'($urandom));
        wait_until(m_end - 1);
        acc(1, 3'd0, 1, 8'h00);
        acc(1, 3'd1, 1, 8'h00);

        // Window decode and unused offsets
        acc(1, 3'd1, 0, 8'h03);
        acc(1, 3'd2, 0, 8'($urandom));
        acc(0, 3'd0, 0, 8'h11);
        acc(0, 3'd1, 0, 8'h00);
        acc(0, 3'd0, 1, 8'h00);
        acc(0, 3'd1, 1, 8'h00);
        acc(1, 3'd1, 1, 8'h00);
        acc(1, 3'd0, 1, 8'h00);
        for (int o = 2; o < 8; o++) acc(1, 3'(o), 1, 8'h00);

        // Random transfers with interleaved accesses
        for (int t = 0; t < 24; t++) begin
            loop = 1'($urandom_range(0, 1));
            pat  = 8'($urandom);
            acc(1, 3'd1, 0, 8'($urandom));
            acc(1, 3'd0, 0, 8'($urandom));
            while (cyc < m_end + 2) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: acc(1, 3'd1, 1, 8'h00);
                    3:       acc(1, 3'd0, 1, 8'h00);
                    4:       if (cyc < m_end) acc(1, 3'd0, 0, 8'($urandom)); else idle(1);
                    5:       acc(1, 3'd1, 0, 8'($urandom));
                    6:       acc(1, 3'($urandom_range(2, 7)), 1, 8'h00);
                    default: idle(1);
                endcase
            end
            acc(1, 3'd0, 1, 8'h00);
        end

        // Reset in the HI phase of bit 3, H=3
        loop = 1'b0; pat = 8'($urandom);
        acc(1, 3'd1, 0, 8'h05);
        acc(1, 3'd0, 0, 8'($urandom));
        wait_until(m_w + 7 * m_h + 1);
        check("pre_rst_sck", sck, 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_sck", sck, 0);
        check("async_rst_cs_n", cs_n, 1);
        check("async_rst_mosi", mosi, 0);
        m_reset();
        mq.delete();
        idle(2);
        rst = 1'b0;
        idle(1);
        acc(1, 3'd1, 1, 8'h00);
        acc(1, 3'd0, 1, 8'h00);

        idle(4);
        check("rdq_drained", rdq.size(), 0);
        check("mq_drained", mq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
